// File: rtl/sram_macro_pkg.sv
// Shared constants and access decode for the 4Kx64 single-port SRAM macro model.
package sram_macro_pkg;

  localparam int unsigned SRAM4K_DEPTH = 4096;
  localparam int unsigned SRAM4K_WIDTH = 64;
  localparam int unsigned SRAM4K_AW    = 12;

  typedef enum logic [2:0] {
    OpReset,
    OpClear,
    OpBypass,
    OpIdle,
    OpRead,
    OpWrite
  } sram_op_e;

  // Resolves the per-edge action; earlier conditions take precedence.
  function automatic sram_op_e sram_op_decode(input logic rst_n, input logic t_q_rst,
                                              input logic t_logic, input logic cen,
                                              input logic rdwen);
    sram_op_e op;
    if (!rst_n)       op = OpReset;
    else if (t_q_rst) op = OpClear;
    else if (t_logic) op = OpBypass;
    else if (cen)     op = OpIdle;
    else if (rdwen)   op = OpRead;
    else              op = OpWrite;
    return op;
  endfunction

endpackage

// File: rtl/in12lp_s1db_w04096b064m08s2_hb.sv
// Behavioral 4096x64 single-port SRAM with bit write mask, registered read port and
// test-logic bypass/clear of the output register.
module in12lp_s1db_w04096b064m08s2_hb
  import sram_macro_pkg::*;
#(
  parameter int unsigned DEPTH     = SRAM4K_DEPTH,
  parameter int unsigned WIDTH     = SRAM4K_WIDTH,
  parameter string       INIT_FILE = "",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             CEN,
  input  logic             RDWEN,
  input  logic [WIDTH-1:0] BW,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  input  logic             MA_SAWL0,
  input  logic             MA_SAWL1,
  input  logic             MA_STABAS0,
  input  logic             MA_STABAS1,
  input  logic             MA_VD0,
  input  logic             MA_VD1,
  input  logic             MA_WL0,
  input  logic             MA_WL1,
  input  logic             MA_WRAS0,
  input  logic             MA_WRAS1,
  input  logic             MA_WRT,
  input  logic             T_LOGIC,
  input  logic             T_Q_RST
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] q_d, q_q;
  sram_op_e         op;

  // Margin-adjust pins are present only for pin compatibility.
  logic unused_ma;
  assign unused_ma = ^{MA_SAWL0, MA_SAWL1, MA_STABAS0, MA_STABAS1, MA_VD0, MA_VD1,
                       MA_WL0, MA_WL1, MA_WRAS0, MA_WRAS1, MA_WRT};

  always_comb begin
    op = sram_op_decode(RESETn, T_Q_RST, T_LOGIC, CEN, RDWEN);
  end

  always_comb begin
    q_d = q_q;
    unique case (op)
      OpReset, OpClear: q_d = '0;
      OpBypass:         q_d = D;
      OpRead:           q_d = mem[A];
      default:          q_d = q_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    q_q <= q_d;
  end

  // Masked write merges new bits into the stored word; Q is not disturbed.
  always_ff @(posedge CLK) begin
    if (op == OpWrite) begin
      mem[A] <= (mem[A] & ~BW) | (D & BW);
    end
  end

  assign Q = q_q;

endmodule

// File: tb/tb_in12lp_s1db_w04096b064m08s2_hb.sv
// Self-checking bench: directed test-plan sequences plus randomized traffic against a
// behavioural model of the macro.
module tb_in12lp_s1db_w04096b064m08s2_hb;
  import sram_macro_pkg::*;

  localparam int unsigned W  = SRAM4K_WIDTH;
  localparam int unsigned AW = SRAM4K_AW;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic          clk = 1'b0;
  logic          rstn, cen, rdwen, tlogic, tqrst;
  logic [W-1:0]  bw, d, q;
  logic [AW-1:0] a;
  logic [10:0]   ma;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] ref_mem [int];
  logic [W-1:0] exp_q;
  logic [AW-1:0] pool [16];

  always #5 clk = ~clk;

  in12lp_s1db_w04096b064m08s2_hb dut (
    .CLK        (clk),
    .RESETn     (rstn),
    .CEN        (cen),
    .RDWEN      (rdwen),
    .BW         (bw),
    .A          (a),
    .D          (d),
    .Q          (q),
    .MA_SAWL0   (ma[0]),
    .MA_SAWL1   (ma[1]),
    .MA_STABAS0 (ma[2]),
    .MA_STABAS1 (ma[3]),
    .MA_VD0     (ma[4]),
    .MA_VD1     (ma[5]),
    .MA_WL0     (ma[6]),
    .MA_WL1     (ma[7]),
    .MA_WRAS0   (ma[8]),
    .MA_WRAS1   (ma[9]),
    .MA_WRT     (ma[10]),
    .T_LOGIC    (tlogic),
    .T_Q_RST    (tqrst)
  );

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Model of one clock edge, written directly from the priority rules.
  task automatic model_edge();
    logic [W-1:0] old;
    if (!rstn || tqrst) begin
      exp_q = '0;
    end else if (tlogic) begin
      exp_q = d;
    end else if (!cen) begin
      if (rdwen) begin
        exp_q = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : {W{1'bx}};
      end else begin
        old = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : {W{1'bx}};
        for (int i = 0; i < int'(W); i++) begin
          if (bw[i]) old[i] = d[i];
        end
        ref_mem[int'(a)] = old;
      end
    end
  endtask

  task automatic tick(input string tag, input bit do_check);
    model_edge();
    @(posedge clk);
    #1;
    if (do_check) check_eq(tag, q, exp_q);
  endtask

  task automatic set_idle();
    rstn = 1'b1; cen = 1'b1; rdwen = 1'b1; tlogic = 1'b0; tqrst = 1'b0;
    bw = '0; d = '0; a = '0; ma = '0;
  endtask

  task automatic do_write(input string tag, input logic [AW-1:0] addr,
                          input logic [W-1:0] data, input logic [W-1:0] mask);
    set_idle();
    cen = 1'b0; rdwen = 1'b0; a = addr; d = data; bw = mask;
    tick(tag, 1'b1);
  endtask

  task automatic do_read(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
    set_idle();
    cen = 1'b0; a = addr;
    tick(tag, 1'b1);
    check_eq({tag, "_const"}, q, exp);
  endtask

  initial begin
    set_idle();
    exp_q = 'x;

    // Reset: held two cycles, then release while idle.
    rstn = 1'b0;
    tick("reset0", 1'b1);
    tick("reset1", 1'b1);
    check_eq("reset_q_zero", q, '0);
    rstn = 1'b1;
    tick("release_idle", 1'b1);
    check_eq("release_q_zero", q, '0);

    // Full-word writes at both address extremes.
    do_write("wr_000", 12'h000, 64'h0123_4567_89AB_CDEF, ONES);
    do_write("wr_fff", 12'hFFF, 64'hDEAD_BEEF_CAFE_F00D, ONES);
    do_read("rd_000", 12'h000, 64'h0123_4567_89AB_CDEF);
    do_read("rd_fff", 12'hFFF, 64'hDEAD_BEEF_CAFE_F00D);

    // Masked write: only the low byte is cleared.
    do_write("fill_100", 12'h100, ONES, ONES);
    do_write("mask_100", 12'h100, 64'h0, 64'h0000_0000_0000_00FF);
    do_read("rd_100", 12'h100, 64'hFFFF_FFFF_FFFF_FF00);
    do_write("bw0_100", 12'h100, 64'h0, 64'h0);
    do_read("rd_100_bw0", 12'h100, 64'hFFFF_FFFF_FFFF_FF00);

    // Write and idle cycles hold Q.
    do_write("wr_200", 12'h200, 64'hAAAA_AAAA_AAAA_AAAA, ONES);
    do_read("rd_200", 12'h200, 64'hAAAA_AAAA_AAAA_AAAA);
    do_write("hold_wr", 12'h201, 64'h1111_2222_3333_4444, ONES);
    check_eq("hold_after_wr", q, 64'hAAAA_AAAA_AAAA_AAAA);
    set_idle();
    tick("hold_idle", 1'b1);
    check_eq("hold_after_idle", q, 64'hAAAA_AAAA_AAAA_AAAA);
    do_read("rd_201", 12'h201, 64'h1111_2222_3333_4444);

    // Bypass with a write pattern on the bus must not touch the array.
    set_idle();
    tlogic = 1'b1; cen = 1'b0; rdwen = 1'b0; a = 12'h000; bw = ONES;
    d = 64'h5555_5555_5555_5555;
    tick("bypass", 1'b1);
    check_eq("bypass_q_d", q, 64'h5555_5555_5555_5555);
    do_read("rd_000_post_bypass", 12'h000, 64'h0123_4567_89AB_CDEF);
    set_idle();
    tqrst = 1'b1; tlogic = 1'b1; d = ONES;
    tick("tqrst", 1'b1);
    check_eq("tqrst_zero", q, '0);

    // Margin pins are inert.
    set_idle();
    ma = 11'h7FF; cen = 1'b0; a = 12'hFFF;
    tick("ma_read", 1'b1);
    check_eq("ma_read_val", q, 64'hDEAD_BEEF_CAFE_F00D);

    // Reset sampled with a read discards it; the next read is normal.
    set_idle();
    rstn = 1'b0; cen = 1'b0; a = 12'h000;
    tick("rst_mid_read", 1'b1);
    check_eq("rst_mid_read_zero", q, '0);
    do_read("rd_after_rst", 12'h000, 64'h0123_4567_89AB_CDEF);

    // Randomized traffic over a prefilled address pool.
    for (int i = 0; i < 16; i++) begin
      pool[i] = AW'($urandom_range(0, 4095));
      do_write("prefill", pool[i], {$urandom, $urandom}, ONES);
    end
    for (int n = 0; n < 600; n++) begin
      int sel;
      rstn   = ($urandom_range(0, 99) >= 4);
      tqrst  = ($urandom_range(0, 99) < 4);
      tlogic = ($urandom_range(0, 99) < 6);
      cen    = ($urandom_range(0, 99) < 20);
      rdwen  = $urandom_range(0, 1) == 1;
      a      = pool[$urandom_range(0, 15)];
      d      = {$urandom, $urandom};
      sel    = $urandom_range(0, 9);
      bw     = (sel == 0) ? '0 : (sel == 1) ? ONES : {$urandom, $urandom};
      ma     = 11'($urandom);
      tick("rand", 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
